fv_sb_wolper_ctrl: RTL and testbench

Synthesizable sequencer for a single-symbol Wolper data-integrity check on a push/pop datapath. It arms one tracked symbol on request and follows it through the states *not yet pushed*, *in flight* and *popped*. It measures push-to-pop latency and raises sticky error flags for causality, duplication, resend and timeout violations. It sits beside the DUT's ingress/egress ports in formal and simulation benches, and its flags can be driven to a bench status register.

---
 rtl/fv_sb_pkg.sv | 22 ++
 rtl/fv_sb_sat_counter.sv | 38 +++
 rtl/fv_sb_wolper_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_fv_sb_wolper_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fv_sb_pkg.sv
// fv_sb_pkg
// Shared types and helpers for the single-symbol Wolper scoreboard sequencer.
//   fv_sb_wolper_state_e : sequencer states (IDLE, ARMED, INFLIGHT, CHECK)
//   fv_sb_lat_width()    : bit width needed to hold a latency of 0..max_lat
package fv_sb_pkg;

  typedef enum logic [1:0] {
    FV_SB_IDLE     = 2'd0,
    FV_SB_ARMED    = 2'd1,
    FV_SB_INFLIGHT = 2'd2,
    FV_SB_CHECK    = 2'd3
  } fv_sb_wolper_state_e;

  // A latency of exactly max_lat must be representable.
  function automatic int fv_sb_lat_width(input int max_lat);
    int w;
    w = $clog2(max_lat + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/fv_sb_sat_counter.sv
// fv_sb_sat_counter
// Saturating up-counter with synchronous clear and count enable.
// Clear has priority over enable; the count holds at MAX once reached.
// Ports:
//   clk   in  clock
//   rstn  in  asynchronous active-low reset (count -> 0)
//   clr   in  synchronous clear to 0
//   en    in  increment by one (saturating at MAX)
//   count out current count, WIDTH bits
module fv_sb_sat_counter #(
  parameter int WIDTH = 4,
  parameter int MAX   = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;
  logic             w_at_max;

  assign w_at_max = (r_count == WIDTH'(MAX));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en && !w_at_max) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/fv_sb_wolper_ctrl.sv
// fv_sb_wolper_ctrl
// Sequencer for a single-symbol Wolper data-integrity check on a push/pop
// datapath. One symbol is armed, then followed through "not yet pushed"
// (ARMED), "in flight" (INFLIGHT) and "popped" (CHECK). Push-to-pop latency
// is measured and sticky error flags record causality, duplication, resend
// and timeout violations.
//
// Optional feature: define FV_SB_WOLPER_CTRL_ASSERT_EN to compile in
// concurrent assertions that no err_* flag ever rises, plus a cover on done.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   arm, arm_data        request to track arm_data (accepted in IDLE/CHECK)
//   clr                  synchronous return to IDLE, clears flags and latency
//   push_valid/push_data DUT ingress
//   pop_valid/pop_data   DUT egress
//   busy                 state is ARMED or INFLIGHT
//   done                 one-cycle pulse when the tracked symbol is popped
//   latency              push-to-pop cycles of the last completed check
//   err_causality        sticky: popped before pushed
//   err_dup              sticky: popped more than once
//   err_resend           sticky: pushed more than once
//   err_timeout          sticky: in flight for MAX_LAT cycles without a pop
module fv_sb_wolper_ctrl
  import fv_sb_pkg::*;
#(
  parameter  int DWIDTH  = 4,
  parameter  int MAX_LAT = 8,
  localparam int LWIDTH  = fv_sb_lat_width(MAX_LAT)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              arm,
  input  logic [DWIDTH-1:0] arm_data,
  input  logic              clr,
  input  logic              push_valid,
  input  logic [DWIDTH-1:0] push_data,
  input  logic              pop_valid,
  input  logic [DWIDTH-1:0] pop_data,
  output logic              busy,
  output logic              done,
  output logic [LWIDTH-1:0] latency,
  output logic              err_causality,
  output logic              err_dup,
  output logic              err_resend,
  output logic              err_timeout
);

  fv_sb_wolper_state_e r_state;
  logic [DWIDTH-1:0]   r_sym;
  logic                r_busy;
  logic                r_done;
  logic [LWIDTH-1:0]   r_latency;
  logic                r_err_causality;
  logic                r_err_dup;
  logic                r_err_resend;
  logic                r_err_timeout;

  logic                w_push_hit;
  logic                w_pop_hit;
  logic                w_cnt_clr;
  logic                w_cnt_en;
  logic [LWIDTH-1:0]   w_cnt;
  logic                w_cnt_last;

  // Matching is qualified by valid so data on idle cycles is never compared.
  assign w_push_hit = push_valid && (push_data == r_sym);
  assign w_pop_hit  = pop_valid  && (pop_data  == r_sym);

  // The counter only runs while in flight; it sits at 0 in every other state,
  // so entering INFLIGHT always starts from 0.
  assign w_cnt_clr  = clr || (r_state != FV_SB_INFLIGHT);
  assign w_cnt_en   = (r_state == FV_SB_INFLIGHT) && !w_pop_hit;

  // The cycle in which the count would reach MAX_LAT without a pop is the
  // timeout cycle; a pop in that same cycle still completes with
  // latency == MAX_LAT.
  assign w_cnt_last = (w_cnt == LWIDTH'(MAX_LAT - 1));

  fv_sb_sat_counter #(
    .WIDTH (LWIDTH),
    .MAX   (MAX_LAT)
  ) u_lat_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (w_cnt_clr),
    .en    (w_cnt_en),
    .count (w_cnt)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state         <= FV_SB_IDLE;
      r_sym           <= '0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_latency       <= '0;
      r_err_causality <= 1'b0;
      r_err_dup       <= 1'b0;
      r_err_resend    <= 1'b0;
      r_err_timeout   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (clr) begin
        // clr overrides every other event, including a same-cycle arm.
        r_state         <= FV_SB_IDLE;
        r_busy          <= 1'b0;
        r_latency       <= '0;
        r_err_causality <= 1'b0;
        r_err_dup       <= 1'b0;
        r_err_resend    <= 1'b0;
        r_err_timeout   <= 1'b0;
      end else begin
        case (r_state)
          FV_SB_IDLE: begin
            if (arm) begin
              r_sym   <= arm_data;
              r_state <= FV_SB_ARMED;
              r_busy  <= 1'b1;
            end
          end

          FV_SB_ARMED: begin
            if (w_push_hit && w_pop_hit) begin
              r_latency <= '0;
              r_done    <= 1'b1;
              r_state   <= FV_SB_CHECK;
              r_busy    <= 1'b0;
            end else if (w_push_hit) begin
              r_state <= FV_SB_INFLIGHT;
            end else if (w_pop_hit) begin
              r_err_causality <= 1'b1;
            end
          end

          FV_SB_INFLIGHT: begin
            if (w_pop_hit) begin
              r_latency <= w_cnt + LWIDTH'(1);
              r_done    <= 1'b1;
              r_state   <= FV_SB_CHECK;
              r_busy    <= 1'b0;
            end else if (w_cnt_last) begin
              r_err_timeout <= 1'b1;
              r_state       <= FV_SB_IDLE;
              r_busy        <= 1'b0;
            end
            // A second push is flagged but does not disturb the check.
            if (w_push_hit) r_err_resend <= 1'b1;
          end

          FV_SB_CHECK: begin
            // Pop/push comparisons use the symbol just checked, even when a
            // new arm recaptures in the same cycle.
            if (w_pop_hit)  r_err_dup    <= 1'b1;
            if (w_push_hit) r_err_resend <= 1'b1;
            if (arm) begin
              r_sym   <= arm_data;
              r_state <= FV_SB_ARMED;
              r_busy  <= 1'b1;
            end
          end

          default: begin
            r_state <= FV_SB_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign latency       = r_latency;
  assign err_causality = r_err_causality;
  assign err_dup       = r_err_dup;
  assign err_resend    = r_err_resend;
  assign err_timeout   = r_err_timeout;

`ifdef FV_SB_WOLPER_CTRL_ASSERT_EN
  a_no_causality : assert property (@(posedge clk) disable iff (!rstn) !$rose(err_causality));
  a_no_dup       : assert property (@(posedge clk) disable iff (!rstn) !$rose(err_dup));
  a_no_resend    : assert property (@(posedge clk) disable iff (!rstn) !$rose(err_resend));
  a_no_timeout   : assert property (@(posedge clk) disable iff (!rstn) !$rose(err_timeout));
  c_done         : cover property  (@(posedge clk) disable iff (!rstn) done);
`else
  // Flags only; no embedded properties in this build.
`endif

endmodule

// File: tb/tb_fv_sb_wolper_ctrl.sv
module tb_fv_sb_wolper_ctrl;

  localparam int DWIDTH  = 4;
  localparam int MAX_LAT = 8;
  localparam int LWIDTH  = 4;

  logic              clk;
  logic              rstn;
  logic              arm;
  logic [DWIDTH-1:0] arm_data;
  logic              clr;
  logic              push_valid;
  logic [DWIDTH-1:0] push_data;
  logic              pop_valid;
  logic [DWIDTH-1:0] pop_data;
  logic              busy;
  logic              done;
  logic [LWIDTH-1:0] latency;
  logic              err_causality;
  logic              err_dup;
  logic              err_resend;
  logic              err_timeout;

  int n_checks;
  int n_errors;

  fv_sb_wolper_ctrl #(
    .DWIDTH  (DWIDTH),
    .MAX_LAT (MAX_LAT)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .arm           (arm),
    .arm_data      (arm_data),
    .clr           (clr),
    .push_valid    (push_valid),
    .push_data     (push_data),
    .pop_valid     (pop_valid),
    .pop_data      (pop_data),
    .busy          (busy),
    .done          (done),
    .latency       (latency),
    .err_causality (err_causality),
    .err_dup       (err_dup),
    .err_resend    (err_resend),
    .err_timeout   (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full output vector: busy, done, latency, causality, dup, resend, timeout.
  task automatic chk_out(input string tag, input logic b, input logic d,
                         input logic [LWIDTH-1:0] lat, input logic c,
                         input logic du, input logic rs, input logic to);
    chk({tag, ".busy"},      32'(busy),          32'(b));
    chk({tag, ".done"},      32'(done),          32'(d));
    chk({tag, ".latency"},   32'(latency),       32'(lat));
    chk({tag, ".causality"}, 32'(err_causality), 32'(c));
    chk({tag, ".dup"},       32'(err_dup),       32'(du));
    chk({tag, ".resend"},    32'(err_resend),    32'(rs));
    chk({tag, ".timeout"},   32'(err_timeout),   32'(to));
  endtask

  task automatic idle_in();
    arm        = 1'b0;
    arm_data   = '0;
    clr        = 1'b0;
    push_valid = 1'b0;
    push_data  = '0;
    pop_valid  = 1'b0;
    pop_data   = '0;
  endtask

  // Let one active edge consume the current inputs, then settle 1 time unit.
  task automatic step();
    @(posedge clk);
    #1;
    idle_in();
  endtask

  task automatic do_arm(input logic [DWIDTH-1:0] s);
    arm = 1'b1; arm_data = s; step();
  endtask

  task automatic do_push(input logic [DWIDTH-1:0] s);
    push_valid = 1'b1; push_data = s; step();
  endtask

  task automatic do_pop(input logic [DWIDTH-1:0] s);
    pop_valid = 1'b1; pop_data = s; step();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle_in();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 0, 0, 0, 0, 0, 0, 0);
    rstn = 1'b1;
    step();
    chk_out("post_reset", 0, 0, 0, 0, 0, 0, 0);

    // Basic: arm 5 (cycle 0), push cycle 2, pop cycle 5 -> latency 3.
    do_arm(4'h5);
    chk("t1.armed_busy", 32'(busy), 32'd1);
    step();
    do_push(4'h5);
    chk("t1.inflight_busy", 32'(busy), 32'd1);
    step();
    step();
    do_pop(4'h5);
    chk_out("t1.done", 0, 1, 4'd3, 0, 0, 0, 0);
    step();
    chk_out("t1.after", 0, 0, 4'd3, 0, 0, 0, 0);

    // Causality: arm 0xA from CHECK, pop before push.
    do_arm(4'hA);
    // Invalid pop with matching data must not be compared.
    pop_valid = 1'b0; pop_data = 4'hA; step();
    chk("t2.invalid_pop", 32'(err_causality), 32'd0);
    do_pop(4'hA);
    chk_out("t2.causality", 1, 0, 4'd3, 1, 0, 0, 0);
    clr = 1'b1; step();
    chk_out("t2.clr", 0, 0, 0, 0, 0, 0, 0);

    // Timeout: arm 3, push, no matching pop for 8 cycles.
    do_arm(4'h3);
    do_push(4'h3);
    for (int i = 0; i < 7; i++) begin
      pop_valid = 1'b1; pop_data = 4'h4; step();
    end
    chk_out("t3.pre_timeout", 1, 0, 0, 0, 0, 0, 0);
    step();
    chk_out("t3.timeout", 0, 0, 0, 0, 0, 0, 1);
    do_pop(4'h3);
    chk("t3.idle_pop_causality", 32'(err_causality), 32'd0);
    clr = 1'b1; step();

    // Same-cycle push/pop: latency 0, then a duplicate pop.
    do_arm(4'h7);
    push_valid = 1'b1; push_data = 4'h7;
    pop_valid  = 1'b1; pop_data  = 4'h7;
    step();
    chk_out("t4.done0", 0, 1, 0, 0, 0, 0, 0);
    step();
    chk("t4.done_pulse", 32'(done), 32'd0);
    do_pop(4'h7);
    chk_out("t4.dup", 0, 0, 0, 0, 1, 0, 0);
    clr = 1'b1; step();

    // Resend, then clr together with arm.
    do_arm(4'h2);
    do_push(4'h2);
    do_push(4'h2);
    chk_out("t5.resend", 1, 0, 0, 0, 0, 1, 0);
    clr = 1'b1; arm = 1'b1; arm_data = 4'h2; step();
    chk_out("t5.clr_arm", 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("t5.arm_ignored", 32'(busy), 32'd0);
    do_pop(4'h2);
    chk("t5.idle_pop", 32'(err_causality), 32'd0);

    // Boundary: pop on the last in-flight cycle -> latency MAX_LAT, no timeout.
    // An arm while ARMED is ignored; invalid pops with matching data ignored.
    do_arm(4'h1);
    do_arm(4'hE);
    do_push(4'h1);
    for (int i = 0; i < 7; i++) begin
      pop_valid = 1'b0; pop_data = 4'h1; step();
    end
    do_pop(4'h1);
    chk_out("t6.maxlat", 0, 1, 4'd8, 0, 0, 0, 0);

    // Reset mid-check: build latency and a flag, then reset while INFLIGHT.
    do_arm(4'h9);
    do_push(4'h9);
    do_pop(4'h9);
    chk("t7.lat1", 32'(latency), 32'd1);
    do_arm(4'h9);
    do_push(4'h9);
    do_push(4'h9);
    chk_out("t7.pre_reset", 1, 0, 4'd1, 0, 0, 1, 0);
    rstn = 1'b0;
    #2;
    chk_out("t7.in_reset", 0, 0, 0, 0, 0, 0, 0);
    step();
    rstn = 1'b1;
    step();
    do_pop(4'h9);
    chk_out("t7.after_reset_pop", 0, 0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
